alu_arbiter: RTL and testbench

Shares one instance of the team's 16-bit, 2-bit-opcode `alu` between `N_REQ` requesters. The block arbitrates valid/ready operation requests, registers the winning operands into the ALU, and captures the result. It returns the result with the requester index on a single valid/ready response channel. It sits between the requesting control units and the shared combinational ALU, and is the only block allowed to drive the ALU inputs.

---
 rtl/alu_arb_pkg.sv | 6 +
 rtl/alu.sv | 15 +
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: FSM states and width constants shared by the alu arbiter slice.
package alu_arb_pkg;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam int SEL_W     = 2;
   localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/alu.sv
// alu: shared combinational ALU; sel 0 add, 1 sub, 2 and, 3 or.
module alu
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [SEL_W-1:0] i_sel,
   output logic [WIDTH-1:0] o_y
);
   assign o_y = (i_sel == 2'd0) ? i_a + i_b :
                (i_sel == 2'd1) ? i_a - i_b :
                (i_sel == 2'd2) ? i_a & i_b : i_a | i_b;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu among N_REQ valid/ready requesters, round-robin by default.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int ID_W  = $clog2(N_REQ)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*SEL_W-1:0] req_sel,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id
);
   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_rsp_data, w_y;
   logic [SEL_W-1:0] r_sel;
   logic [ID_W-1:0]  r_id, r_rsp_id, w_gnt;
   logic             r_rsp_valid, w_gnt_vld, w_accept;
`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (req_valid[k]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ID_W'(k);
         end
   end
`else
   logic [ID_W-1:0] r_last, w_idx;
   // scan downward so the nearest valid index after r_last is written last and wins
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_idx     = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_idx = ID_W'((int'(r_last) + k) % N_REQ);
         if (req_valid[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx;
         end
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst)
         r_last <= ID_W'(N_REQ - 1);
      else if (w_accept)
         r_last <= w_gnt;
`endif
   assign w_accept  = (r_state == IDLE) && w_gnt_vld;
   assign req_ready = (w_accept && !rst) ? N_REQ'(1) << w_gnt : '0;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sel       <= '0;
         r_id        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= '0;
      end else
         case (r_state)
            IDLE: if (w_accept) begin
               r_a     <= req_a[int'(w_gnt)*WIDTH +: WIDTH];
               r_b     <= req_b[int'(w_gnt)*WIDTH +: WIDTH];
               r_sel   <= req_sel[int'(w_gnt)*SEL_W +: SEL_W];
               r_id    <= w_gnt;
               r_state <= EXEC;
            end
            EXEC: begin
               r_rsp_data  <= w_y;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
   alu #(.WIDTH(WIDTH)) u_alu (
      .i_a  (r_a),
      .i_b  (r_b),
      .i_sel(r_sel),
      .o_y  (w_y)
   );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with 4 requesters of 16 bits.
module tb_alu_arbiter;
   logic        clk, rst, rsp_valid, rsp_ready;
   logic [3:0]  req_valid, req_ready;
   logic [63:0] req_a, req_b;
   logic [7:0]  req_sel;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_id;
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_tbl [4] = '{16'h1112, 16'h2220, 16'h0003, 16'h4444};
   logic [15:0] sweep_tbl [4] = '{16'h00FC, 16'h00F8, 16'h0002, 16'h00FA};
   alu_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
      req_sel[i*2 +: 2] = s;
   endtask
   // called at a negedge in IDLE with requests driven; returns at the negedge after the response handshake
   task automatic do_op(input string tag, input logic [3:0] exp_rdy, input logic [1:0] exp_id, input logic [15:0] exp_d);
      #1 chk({tag, "_ready"}, req_ready, exp_rdy);
      @(posedge clk); @(negedge clk);
      chk({tag, "_exec_ready"}, req_ready, 0);
      chk({tag, "_exec_valid"}, rsp_valid, 0);
      @(posedge clk); @(negedge clk);
      chk({tag, "_valid"}, rsp_valid, 1);
      chk({tag, "_id"}, rsp_id, exp_id);
      chk({tag, "_data"}, rsp_data, exp_d);
      @(posedge clk); @(negedge clk);
   endtask
   initial begin
      rst = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      rst = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         set_req(0, 16'h00FA, 16'h0002, 2'(s));
         req_valid = 4'b0001;
         do_op($sformatf("sweep%0d", s), 4'b0001, 2'd0, sweep_tbl[s]);
      end
      req_valid = 4'b0010;
      #1 chk("mid_rst_accept", req_ready, 4'b0010);
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_data", rsp_data, 0);
      chk("mid_rst_id", rsp_id, 0);
      req_valid = '0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("mid_rst_quiet%0d", k), rsp_valid, 0);
      end
      for (int i = 0; i < 4; i++)
         set_req(i, 16'(16'h1111 * (i + 1)), 16'(i + 1), 2'(i));
      for (int i = 0; i < 5; i++) begin
         int e;
`ifdef ALU_ARB_FIXED_PRIO_EN
         e = 0;
`else
         e = i % 4;
`endif
         req_valid = 4'b1111;
         do_op($sformatf("all%0d", i), 4'(1 << e), 2'(e), exp_tbl[e]);
      end
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1 chk("bp_accept", req_ready, 4'b0010);
      @(posedge clk); @(negedge clk);
      req_valid = 4'b1111;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
         chk($sformatf("bp%0d_data", k), rsp_data, 16'h2220);
         chk($sformatf("bp%0d_id", k), rsp_id, 1);
         chk($sformatf("bp%0d_ready", k), req_ready, 0);
         @(posedge clk);
      end
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b1;
      chk("bp_last_valid", rsp_valid, 1);
      @(posedge clk); @(negedge clk);
      chk("bp_done_valid", rsp_valid, 0);
      @(posedge clk); @(negedge clk);
      chk("bp_once_valid", rsp_valid, 0);
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      #1 chk("wd_accept", req_ready, 4'b0001);
      @(posedge clk); @(negedge clk);
      req_valid = 4'b0100;
      #1 chk("wd_exec_ready", req_ready, 0);
      @(posedge clk); @(negedge clk);
      chk("wd_resp_ready", req_ready, 0);
      chk("wd_resp_id", rsp_id, 0);
      chk("wd_resp_data", rsp_data, 16'h1112);
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 4'b1000;
      do_op("wd_next", 4'b1000, 2'd3, 16'h4444);
      req_valid = 4'b1001;
      do_op("wrap", 4'b0001, 2'd0, 16'h1112);
      req_valid = '0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
